elevator_ctrl_nfloor: RTL

//  Parametrised N-floor elevator controller using collective (SCAN) scheduling. Next generation of the fixed 6-floor controller.

---
 rtl/elevator_ctrl_nfloor.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_ctrl_nfloor.sv
// elevator_ctrl_nfloor: N-floor collective (SCAN) elevator controller with timed travel and doors.
// Defining ELEV_DOOR_HOLD_EN adds a door_hold input that keeps or reopens the door.
module elevator_ctrl_nfloor #(
   parameter int unsigned NUM_FLOORS = 6,
   parameter int unsigned TRAVEL_CYC = 50000000,
   parameter int unsigned DOOR_CYC   = 100000000,
   parameter int unsigned CLOSE_CYC  = 50000000,
   localparam int unsigned FW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
   input  logic                  clk_50M,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic [1:0]            req_kind,
   input  logic [FW-1:0]         req_floor,
`ifdef ELEV_DOOR_HOLD_EN
   input  logic                  door_hold,
`endif
   output logic [FW-1:0]         cur_floor,
   output logic [NUM_FLOORS-1:0] pend_cabin,
   output logic [NUM_FLOORS-1:0] pend_up,
   output logic [NUM_FLOORS-1:0] pend_down,
   output logic [1:0]            direction,
   output logic                  door_open,
   output logic                  door_closing,
   output logic                  moving
);

   localparam int unsigned TMax0  = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
   localparam int unsigned TMax   = (TMax0 > CLOSE_CYC) ? TMax0 : CLOSE_CYC;
   localparam int unsigned TimerW = (TMax > 1) ? $clog2(TMax) : 1;

   // Timers count down from (cycles - 1) and expire when they reach zero.
   localparam logic [TimerW-1:0]     TravelLd = TimerW'(TRAVEL_CYC - 1);
   localparam logic [TimerW-1:0]     DoorLd   = TimerW'(DOOR_CYC - 1);
   localparam logic [TimerW-1:0]     CloseLd  = TimerW'(CLOSE_CYC - 1);
   localparam logic [FW-1:0]         TopFloor = FW'(NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] OneHot0  = NUM_FLOORS'(1);

   typedef enum logic [2:0] {StIdle, StMoveUp, StMoveDown, StDoorOpen, StDoorClose} state_e;

   state_e                  state_q, state_d;
   logic [TimerW-1:0]       timer_q, timer_d;
   logic [FW-1:0]           floor_q, floor_d, next_fl;
   logic [1:0]              dir_q, dir_d;
   logic [NUM_FLOORS-1:0]   cab_q, cab_d, up_q, up_d, dn_q, dn_d;
   logic [NUM_FLOORS-1:0]   any_req, req_bit, door_bit, clr_up, clr_dn;
   logic                    req_ok, req_here, tmr_zero, enter_open, stop;
   logic                    go_dn, ahead, behind, hold;

   function automatic logic mask_above(input logic [NUM_FLOORS-1:0] m, input logic [FW-1:0] fl);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (i > 32'(fl)) r = r | m[i];
      end
      return r;
   endfunction

   function automatic logic mask_below(input logic [NUM_FLOORS-1:0] m, input logic [FW-1:0] fl);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (i < 32'(fl)) r = r | m[i];
      end
      return r;
   endfunction

`ifdef ELEV_DOOR_HOLD_EN
   assign hold = door_hold;
`else
   assign hold = 1'b0;
`endif

   assign any_req = cab_q | up_q | dn_q;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         timer_q <= '0;
         floor_q <= '0;
         dir_q   <= 2'b00;
         cab_q   <= '0;
         up_q    <= '0;
         dn_q    <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         floor_q <= floor_d;
         dir_q   <= dir_d;
         cab_q   <= cab_d;
         up_q    <= up_d;
         dn_q    <= dn_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      floor_d    = floor_q;
      dir_d      = dir_q;
      next_fl    = floor_q;
      enter_open = 1'b0;
      stop       = 1'b0;
      go_dn      = (dir_q == 2'b10);
      ahead      = 1'b0;
      behind     = 1'b0;
      tmr_zero   = (timer_q == '0);

      req_ok   = req_valid && (req_kind != 2'd3) && (req_floor <= TopFloor)
                 && !(req_kind == 2'd1 && req_floor == TopFloor)
                 && !(req_kind == 2'd2 && req_floor == '0);
      // A call at the current floor with the door available is served, not latched.
      req_here = req_ok && (req_floor == floor_q)
                 && (state_q == StIdle || state_q == StDoorOpen);

      unique case (state_q)
         StIdle: begin
            if (req_here) begin
               enter_open = 1'b1;
            end else if (mask_above(any_req, floor_q)) begin
               state_d = StMoveUp;
               dir_d   = 2'b01;
               timer_d = TravelLd;
            end else if (mask_below(any_req, floor_q)) begin
               state_d = StMoveDown;
               dir_d   = 2'b10;
               timer_d = TravelLd;
            end
         end
         StMoveUp: begin
            if (!tmr_zero) begin
               timer_d = timer_q - TimerW'(1);
            end else begin
               next_fl = (floor_q == TopFloor) ? floor_q : floor_q + FW'(1);
               floor_d = next_fl;
               stop    = cab_q[next_fl] | up_q[next_fl]
                         | (dn_q[next_fl] & !mask_above(any_req, next_fl))
                         | (next_fl == TopFloor);
               if (stop) enter_open = 1'b1;
               else      timer_d    = TravelLd;
            end
         end
         StMoveDown: begin
            if (!tmr_zero) begin
               timer_d = timer_q - TimerW'(1);
            end else begin
               next_fl = (floor_q == '0) ? floor_q : floor_q - FW'(1);
               floor_d = next_fl;
               stop    = cab_q[next_fl] | dn_q[next_fl]
                         | (up_q[next_fl] & !mask_below(any_req, next_fl))
                         | (next_fl == '0);
               if (stop) enter_open = 1'b1;
               else      timer_d    = TravelLd;
            end
         end
         StDoorOpen: begin
            if (req_here || hold) begin
               timer_d = DoorLd;
            end else if (tmr_zero) begin
               state_d = StDoorClose;
               timer_d = CloseLd;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StDoorClose: begin
            if (hold) begin
               enter_open = 1'b1;
            end else if (!tmr_zero) begin
               timer_d = timer_q - TimerW'(1);
            end else begin
               // An idle direction (00) prefers up, same as the IDLE tie-break.
               ahead  = go_dn ? mask_below(any_req, floor_q) : mask_above(any_req, floor_q);
               behind = go_dn ? mask_above(any_req, floor_q) : mask_below(any_req, floor_q);
               if (ahead) begin
                  state_d = go_dn ? StMoveDown : StMoveUp;
                  dir_d   = go_dn ? 2'b10 : 2'b01;
                  timer_d = TravelLd;
               end else if (behind) begin
                  state_d = go_dn ? StMoveUp : StMoveDown;
                  dir_d   = go_dn ? 2'b01 : 2'b10;
                  timer_d = TravelLd;
               end else if (any_req[floor_q]) begin
                  enter_open = 1'b1;
               end else begin
                  state_d = StIdle;
                  dir_d   = 2'b00;
                  timer_d = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase

      if (enter_open) begin
         state_d = StDoorOpen;
         timer_d = DoorLd;
      end

      // Clears use the pre-request masks; a clear beats a same-edge set at the door floor.
      door_bit = enter_open ? (OneHot0 << floor_d) : '0;
      req_bit  = (req_ok && !req_here) ? (OneHot0 << req_floor) : '0;
      clr_up   = (dir_d != 2'b10 || !mask_below(any_req, floor_d)) ? door_bit : '0;
      clr_dn   = (dir_d != 2'b01 || !mask_above(any_req, floor_d)) ? door_bit : '0;
      cab_d    = (cab_q | ((req_kind == 2'd0) ? req_bit : '0)) & ~door_bit;
      up_d     = (up_q  | ((req_kind == 2'd1) ? req_bit : '0)) & ~clr_up;
      dn_d     = (dn_q  | ((req_kind == 2'd2) ? req_bit : '0)) & ~clr_dn;
   end

   always_comb begin
      cur_floor    = floor_q;
      pend_cabin   = cab_q;
      pend_up      = up_q;
      pend_down    = dn_q;
      direction    = dir_q;
      door_open    = (state_q == StDoorOpen);
      door_closing = (state_q == StDoorClose);
      moving       = (state_q == StMoveUp) || (state_q == StMoveDown);
   end

endmodule
